div_scheduler: RTL and testbench

//  Shares the single pipelined signed divider (32b numer / 22b denom -> 20b quotient) between

---
 rtl/div_scheduler.sv | 164 ++++++++++++++++
 tb/tb_div_scheduler.sv | 318 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/div_scheduler.sv
// Round-robin scheduler sharing one pipelined signed divider between NREQ requesters.
// Owner tags ride a latency-matched shift register so each quotient returns to its issuer.
module div_scheduler #(
    parameter int NREQ    = 4,
    parameter int DIV_LAT = 5
) (
    input  logic                 clock,
    input  logic                 i_nRst,
    input  logic                 i_flush,
    input  logic [NREQ-1:0]      i_reqValid,
    output logic [NREQ-1:0]      o_reqReady,
    input  logic [NREQ*32-1:0]   i_reqNumer,
    input  logic [NREQ*22-1:0]   i_reqDenom,
    output logic [31:0]          o_divNumer,
    output logic [21:0]          o_divDenom,
    input  logic [19:0]          i_divQuot,
    output logic [NREQ-1:0]      o_resValid,
    output logic [19:0]          o_result,
    output logic                 o_resDiv0,
    output logic                 o_busy
);

    localparam int OW   = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int NSTG = DIV_LAT + 1;

    typedef struct packed {
        logic          valid;
        logic [OW-1:0] owner;
        logic          div0;
        logic          sign;
    } tag_t;

    function automatic logic [NREQ-1:0] owner_onehot(input logic [OW-1:0] idx);
        logic [NREQ-1:0] oh;
        oh = '0;
        for (int k = 0; k < NREQ; k++) begin
            oh[k] = (idx == OW'(k));
        end
        return oh;
    endfunction

    // A zero denominator saturates toward the numerator's sign; otherwise the divider value passes through.
    function automatic logic [19:0] sat_quot(input logic div0, input logic sign, input logic [19:0] quot);
        logic [19:0] q;
        if (div0) begin
            q = sign ? 20'h80000 : 20'h7FFFF;
        end else begin
            q = quot;
        end
        return q;
    endfunction

    logic [OW-1:0]   ptr_r;
    logic [OW-1:0]   grant_idx_s;
    logic            grant_hit_s;
    logic            take_s;
    int              cand_s;
    logic [NREQ-1:0] ready_s;
    logic            transfer_s;
    logic [OW-1:0]   ptr_nxt_s;
    logic [31:0]     sel_numer_s;
    logic [21:0]     sel_denom_s;
    tag_t            tag_r [NSTG];
    tag_t            tail_s;
    logic            busy_s;

    // Round-robin search starting at the pointer, first valid requester wins.
    always_comb begin
        grant_idx_s = '0;
        grant_hit_s = 1'b0;
        take_s      = 1'b0;
        cand_s      = 0;
        for (int i = 0; i < NREQ; i++) begin
            cand_s      = (int'(ptr_r) + i) % NREQ;
            take_s      = !grant_hit_s && i_reqValid[cand_s];
            grant_idx_s = take_s ? OW'(cand_s) : grant_idx_s;
            grant_hit_s = grant_hit_s | take_s;
        end
    end

    // Grant decode, operand mux and next-pointer; nothing is granted while reset is held.
    always_comb begin
        ready_s     = '0;
        if (grant_hit_s && i_nRst) begin
            ready_s = owner_onehot(grant_idx_s);
        end else begin
            ready_s = '0;
        end
        transfer_s  = |(i_reqValid & ready_s);
        sel_numer_s = i_reqNumer[int'(grant_idx_s)*32 +: 32];
        sel_denom_s = i_reqDenom[int'(grant_idx_s)*22 +: 22];
        if (grant_idx_s == OW'(NREQ - 1)) begin
            ptr_nxt_s = '0;
        end else begin
            ptr_nxt_s = grant_idx_s + OW'(1);
        end
    end

    assign o_reqReady = ready_s;
    assign tail_s     = tag_r[NSTG-1];

    // Issue register and round-robin pointer advance on each accepted transfer.
    always_ff @(posedge clock or negedge i_nRst) begin
        if (!i_nRst) begin
            ptr_r      <= '0;
            o_divNumer <= 32'd0;
            o_divDenom <= 22'd0;
        end else if (transfer_s) begin
            ptr_r      <= ptr_nxt_s;
            o_divNumer <= sel_numer_s;
            o_divDenom <= sel_denom_s;
        end else begin
            ptr_r      <= ptr_r;
            o_divNumer <= o_divNumer;
            o_divDenom <= o_divDenom;
        end
    end

    // Owner tag pipe aligned with the divider latency; flush kills every stage including the new entry.
    always_ff @(posedge clock or negedge i_nRst) begin
        if (!i_nRst) begin
            for (int i = 0; i < NSTG; i++) begin
                tag_r[i] <= '0;
            end
        end else begin
            tag_r[0] <= '{valid: transfer_s & ~i_flush,
                          owner: grant_idx_s,
                          div0:  (sel_denom_s == 22'd0),
                          sign:  sel_numer_s[31]};
            for (int i = 1; i < NSTG; i++) begin
                tag_r[i]       <= tag_r[i-1];
                tag_r[i].valid <= tag_r[i-1].valid & ~i_flush;
            end
        end
    end

    // Result register: one-hot pulse to the tail owner; value and div0 flag hold when idle.
    always_ff @(posedge clock or negedge i_nRst) begin
        if (!i_nRst) begin
            o_resValid <= '0;
            o_result   <= 20'd0;
            o_resDiv0  <= 1'b0;
        end else if (i_flush) begin
            o_resValid <= '0;
        end else if (tail_s.valid) begin
            o_resValid <= owner_onehot(tail_s.owner);
            o_resDiv0  <= tail_s.div0;
            o_result   <= sat_quot(tail_s.div0, tail_s.sign, i_divQuot);
        end else begin
            o_resValid <= '0;
        end
    end

    // Busy whenever any tag stage holds a live division.
    always_comb begin
        busy_s = 1'b0;
        for (int i = 0; i < NSTG; i++) begin
            busy_s = busy_s | tag_r[i].valid;
        end
    end

    assign o_busy = busy_s;

endmodule

// File: tb/tb_div_scheduler.sv
// Directed bench for div_scheduler with a behavioural 5-stage divider and a short
// randomized stream checked against an independent round-robin / quotient model.
module tb_div_scheduler;

    localparam int NREQ    = 4;
    localparam int DIV_LAT = 5;

    logic               clock = 1'b0;
    logic               i_nRst;
    logic               i_flush;
    logic [NREQ-1:0]    i_reqValid;
    logic [NREQ-1:0]    o_reqReady;
    logic [NREQ*32-1:0] i_reqNumer;
    logic [NREQ*22-1:0] i_reqDenom;
    logic [31:0]        o_divNumer;
    logic [21:0]        o_divDenom;
    logic [19:0]        i_divQuot;
    logic [NREQ-1:0]    o_resValid;
    logic [19:0]        o_result;
    logic               o_resDiv0;
    logic               o_busy;

    int passed = 0;
    int failed = 0;
    int total  = 0;

    typedef struct {
        int          due;
        int          owner;
        logic [20:0] r;
    } exp_t;
    exp_t expq[$];

    always #5 clock = ~clock;

    div_scheduler #(.NREQ(NREQ), .DIV_LAT(DIV_LAT)) dut (
        .clock(clock), .i_nRst(i_nRst), .i_flush(i_flush),
        .i_reqValid(i_reqValid), .o_reqReady(o_reqReady),
        .i_reqNumer(i_reqNumer), .i_reqDenom(i_reqDenom),
        .o_divNumer(o_divNumer), .o_divDenom(o_divDenom), .i_divQuot(i_divQuot),
        .o_resValid(o_resValid), .o_result(o_result), .o_resDiv0(o_resDiv0),
        .o_busy(o_busy)
    );

    function automatic logic [19:0] model_div(input logic [31:0] n, input logic [21:0] d);
        int ni;
        int di;
        ni = $signed(n);
        di = $signed({{10{d[21]}}, d});
        if (di == 0) return 20'd0;
        return 20'(ni / di);
    endfunction

    function automatic logic [20:0] gold(input logic [31:0] n, input logic [21:0] d);
        if (d == 22'd0) return {1'b1, (n[31] ? 20'h80000 : 20'h7FFFF)};
        return {1'b0, model_div(n, d)};
    endfunction

    function automatic int rr_pick(input logic [3:0] v, input int p);
        for (int i = 0; i < 4; i++) begin
            int idx;
            idx = (p + i) % 4;
            if (v[idx]) return idx;
        end
        return -1;
    endfunction

    // Divider stand-in: operands sampled each edge, quotient visible DIV_LAT cycles after presentation.
    logic [19:0] dpipe [DIV_LAT];
    always @(posedge clock) begin
        dpipe[0] <= model_div(o_divNumer, o_divDenom);
        for (int i = 1; i < DIV_LAT; i++) dpipe[i] <= dpipe[i-1];
    end
    assign i_divQuot = dpipe[DIV_LAT-1];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clock);
        #1;
    endtask

    task automatic set_op(input int k, input logic [31:0] n, input logic [21:0] d);
        i_reqNumer[32*k +: 32] = n;
        i_reqDenom[22*k +: 22] = d;
    endtask

    task automatic check_res(input int c);
        if (expq.size() > 0 && expq[0].due == c) begin
            chk("rnd_valid",  32'(o_resValid), 32'd1 << expq[0].owner);
            chk("rnd_result", 32'(o_result),   32'(expq[0].r[19:0]));
            chk("rnd_div0",   32'(o_resDiv0),  32'(expq[0].r[20]));
            void'(expq.pop_front());
        end else begin
            chk("rnd_idle", 32'(o_resValid), 32'd0);
        end
    endtask

    logic [3:0]  exp_g  [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    logic [19:0] exp_r  [5] = '{20'hFFFDF, 20'hFFFF0, 20'h7FFFF, 20'h80000, 20'hFFFDF};
    logic        exp_d0 [5] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0};

    logic        seen;
    int          cnt1, cnt3, eg, bptr;
    logic [3:0]  rv;
    logic [31:0] rn [4];
    logic [21:0] rd [4];

    initial begin
        i_nRst = 1'b0; i_flush = 1'b0; i_reqValid = '0; i_reqNumer = '0; i_reqDenom = '0;
        repeat (2) @(posedge clock);
        #1;
        i_reqValid = 4'b0101;
        #1;
        chk("rst_ready",  32'(o_reqReady), 32'd0);
        chk("rst_numer",  o_divNumer,      32'd0);
        chk("rst_denom",  32'(o_divDenom), 32'd0);
        chk("rst_resv",   32'(o_resValid), 32'd0);
        chk("rst_result", 32'(o_result),   32'd0);
        chk("rst_div0",   32'(o_resDiv0),  32'd0);
        chk("rst_busy",   32'(o_busy),     32'd0);
        i_reqValid = '0;
        cyc();
        i_nRst = 1'b1;

        // Single request 1000/7 from requester 0.
        cyc();
        set_op(0, 32'd1000, 22'd7);
        i_reqValid = 4'b0001;
        #1;
        chk("t2_ready", 32'(o_reqReady), 32'd1);
        cyc();
        i_reqValid = '0;
        #1;
        chk("t2_numer", o_divNumer,      32'd1000);
        chk("t2_denom", 32'(o_divDenom), 32'd7);
        chk("t2_busy",  32'(o_busy),     32'd1);
        repeat (5) cyc();
        #1;
        chk("t2_early", 32'(o_resValid), 32'd0);
        cyc();
        #1;
        chk("t2_resv",   32'(o_resValid), 32'd1);
        chk("t2_result", 32'(o_result),   32'd142);
        chk("t2_div0",   32'(o_resDiv0),  32'd0);
        chk("t2_idle",   32'(o_busy),     32'd0);
        cyc();
        #1;
        chk("t2_pulse", 32'(o_resValid), 32'd0);

        // Reset while three divisions are in flight.
        cyc(); i_reqValid = 4'b0001;
        cyc();
        cyc();
        cyc();
        i_nRst = 1'b0;
        #1;
        chk("t1_ready",  32'(o_reqReady), 32'd0);
        chk("t1_numer",  o_divNumer,      32'd0);
        chk("t1_result", 32'(o_result),   32'd0);
        chk("t1_busy",   32'(o_busy),     32'd0);
        chk("t1_resv",   32'(o_resValid), 32'd0);
        cyc();
        i_reqValid = '0;
        i_nRst = 1'b1;
        seen = 1'b0;
        repeat (12) begin
            cyc();
            if (o_resValid != '0) seen = 1'b1;
        end
        chk("t1_no_res", 32'(seen), 32'd0);

        // All four requesters continuously valid: 0,1,2,3,0.
        cyc();
        set_op(0, -32'sd100, 22'd3);
        set_op(1, 32'd64, -22'sd4);
        set_op(2, 32'd5, 22'd0);
        set_op(3, -32'sd5, 22'd0);
        i_reqValid = 4'b1111;
        #1;
        chk("t3_grant0", 32'(o_reqReady), 32'(exp_g[0]));
        for (int k = 1; k < 5; k++) begin
            cyc();
            #1;
            chk("t3_grant", 32'(o_reqReady), 32'(exp_g[k]));
        end
        cyc(); i_reqValid = '0;
        cyc();
        for (int k = 0; k < 5; k++) begin
            cyc();
            #1;
            chk("t3_resv",   32'(o_resValid), 32'(exp_g[k]));
            chk("t3_result", 32'(o_result),   32'(exp_r[k]));
            chk("t3_div0",   32'(o_resDiv0),  32'(exp_d0[k]));
        end
        cyc();
        #1;
        chk("t3_after", 32'(o_resValid), 32'd0);

        // Move pointer to 2 via requester 1, then alternate requesters 1 and 3.
        cyc();
        set_op(1, 32'd21, 22'd4);
        i_reqValid = 4'b0010;
        #1;
        chk("t4_pre_ready", 32'(o_reqReady), 32'b0010);
        cyc(); i_reqValid = '0;
        repeat (5) cyc();
        cyc();
        #1;
        chk("t4_pre_resv",   32'(o_resValid), 32'b0010);
        chk("t4_pre_result", 32'(o_result),   32'd5);
        cyc();
        set_op(3, 32'd9, -22'sd2);
        i_reqValid = 4'b1010;
        #1;
        chk("t4_g0", 32'(o_reqReady), 32'b1000);
        cnt3 = 1; cnt1 = 0;
        cyc();
        #1;
        chk("t4_g1", 32'(o_reqReady), 32'b0010);
        cnt1++;
        cyc();
        #1;
        chk("t4_g2", 32'(o_reqReady), 32'b1000);
        cnt3++;
        for (int k = 3; k < 100; k++) begin
            cyc();
            #1;
            if (o_reqReady == 4'b1000) cnt3++;
            else if (o_reqReady == 4'b0010) cnt1++;
        end
        chk("t4_cnt1", 32'(cnt1), 32'd50);
        chk("t4_cnt3", 32'(cnt3), 32'd50);
        cyc(); i_reqValid = '0;
        repeat (10) cyc();

        // Flush on the cycle-3 edge: only the cycle-4 issue survives.
        cyc();
        set_op(0, 32'd10, 22'd2);
        i_reqValid = 4'b0001;
        cyc();
        cyc();
        cyc();
        i_flush = 1'b1;
        #1;
        chk("t5_ready_flush", 32'(o_reqReady), 32'b0001);
        cyc();
        i_flush = 1'b0;
        set_op(0, 32'd77, -22'sd7);
        #1;
        chk("t5_busy4", 32'(o_busy), 32'd0);
        cyc();
        i_reqValid = '0;
        #1;
        chk("t5_busy5", 32'(o_busy), 32'd1);
        seen = 1'b0;
        repeat (5) begin
            cyc();
            if (o_resValid != '0) seen = 1'b1;
        end
        chk("t5_killed", 32'(seen), 32'd0);
        cyc();
        #1;
        chk("t5_resv",   32'(o_resValid), 32'b0001);
        chk("t5_result", 32'(o_result),   32'h000FFFF5);
        chk("t5_div0",   32'(o_resDiv0),  32'd0);
        cyc();
        #1;
        chk("t5_busy12", 32'(o_busy),     32'd0);
        chk("t5_resv12", 32'(o_resValid), 32'd0);

        // Randomized stream from a fresh reset against the reference model.
        cyc(); i_nRst = 1'b0;
        cyc(); i_nRst = 1'b1;
        rv = '0; bptr = 0;
        for (int k = 0; k < 4; k++) begin rn[k] = '0; rd[k] = '0; end
        for (int c = 0; c < 400; c++) begin
            cyc();
            for (int k = 0; k < 4; k++) begin
                if (!rv[k] && $urandom_range(0, 2) != 0) begin
                    rv[k] = 1'b1;
                    rn[k] = $urandom;
                    rd[k] = ($urandom_range(0, 5) == 0) ? 22'd0 : 22'($urandom);
                    if (rn[k] == 32'h80000000 && rd[k] == 22'h3FFFFF) rd[k] = 22'd1;
                end
                set_op(k, rn[k], rd[k]);
            end
            i_reqValid = rv;
            #1;
            eg = rr_pick(rv, bptr);
            chk("rnd_ready", 32'(o_reqReady), (eg < 0) ? 32'd0 : (32'd1 << eg));
            check_res(c);
            if (eg >= 0) begin
                expq.push_back('{c + 7, eg, gold(rn[eg], rd[eg])});
                bptr = (eg + 1) % 4;
                rv[eg] = 1'b0;
            end
        end
        for (int c = 400; c < 420; c++) begin
            cyc();
            i_reqValid = '0;
            #1;
            check_res(c);
        end
        chk("rnd_drain", 32'(expq.size()), 32'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
